smac_seq_ctrl: RTL and testbench
================================

// Module: smac_seq_ctrl
// PURPOSE
//  Sequencer for one serial-MAC lane without AC3: weight-register -> bit-adder/bit-register -> AC1 -> neg block -> AC2.
//  Walks Pw weight bit-planes (MSB first). For each plane it streams Pa activation bit-planes (MSB first).
//  Drives plane addresses to the act/weight buffers and every write/clear/sign strobe of the datapath.
//  Flags the result on out_ac2 with a one-cycle done pulse.
// PARAMETERS
//  Pa  8  activation bit width (>=2); activation planes per weight plane
//  Pw  4  weight bit width (>=2); weight planes per operation
// PORTS
//  clk        in   1            clock, all state on rising edge
//  rst        in   1            asynchronous, active-high reset
//  start      in   1            request an operation; sampled only in IDLE
//  accum      in   1            captured with start: 1 = add into AC2 (no AC2 clear)
//  abort      in   1            synchronous kill of the running operation
//  ready      out  1            1 in IDLE only
//  busy       out  1            ~ready
//  done       out  1            1-cycle pulse; out_ac2 is final in this cycle
//  act_addr   out  $clog2(Pa)   activation plane index; buffer returns in_act combinationally
//  wei_addr   out  $clog2(Pw)   weight plane index; buffer returns in_wei combinationally
//  we_w       out  1            load weight input register
//  we_br      out  1            load bit register
//  MSB_a      out  1            current activation plane is the sign plane
//  we_ac1     out  1            AC1 shift-and-add
//  cl_en_ac1  out  1            AC1 clear: load instead of shift-add, with first we_ac1 of a pass
//  we_neg     out  1            neg block capture
//  MSB_w      out  1            qualifies we_neg: weight sign plane, negate
//  we_ac2     out  1            AC2 shift-and-add
//  cl_en_ac2  out  1            AC2 clear-load, with first we_ac2 of an op unless accum
// BEHAVIOUR
//  Reset: state IDLE, counters 0, delay line 0.
//  Reset: all strobes/addresses 0, done=0, busy=0, ready=1.
//  FSM: IDLE -(start)-> LOADW -> STREAM(Pa cycles) -> LOADW (next plane) | DRAIN (last plane).
//  FSM: DRAIN (3 cycles) -> DONE (1 cycle, done=1) -> IDLE.
//  LOADW: we_w=1, wei_addr=Pw-1-j, where j = plane counter 0..Pw-1.
//  STREAM: k counts 0..Pa-1. act_addr=Pa-1-k, we_br=1, MSB_a=(k==0).
//  STREAM: wei_addr is held at the value from LOADW.
//  Pipeline, driven by registered delay lines from STREAM:
//   we_ac1 = we_br delayed 1; cl_en_ac1 coincides with we_ac1 of k==0.
//   we_neg = 1 cycle after a pass's last we_ac1; MSB_w=1 on that we_neg iff j==0.
//   we_ac2 = we_neg delayed 1; cl_en_ac2 on the j==0 we_ac2 iff captured accum==0.
//  Passes run back-to-back (Pa+1 cycles each). The next LOADW follows the last STREAM cycle directly.
//  Op latency: start accepted at cycle 0 -> done at cycle Pw*(Pa+1)+4.
//  Addresses are 0 outside LOADW/STREAM.
//  start: ignored unless ready; start in the DONE cycle is ignored.
//  accum: latched on acceptance, stable for the whole op.
//  abort: any non-IDLE state -> IDLE next cycle; delay line cleared; all strobes 0 from that cycle.
//  abort: no done; AC contents undefined.
//  abort with start in IDLE: abort wins, start dropped.
//  rst mid-op: immediate return to reset values; no done pulse, even if rst falls in the DONE cycle.
//  Counters wrap only via FSM transitions; k/j never exceed Pa-1/Pw-1.
// TESTING
//  rst=1 any time -> next sample: all strobes 0, ready=1, busy=0, done=0.
//  Pa=8,Pw=4, start@0,accum=0 -> we_w@1,10,19,28; we_br@2-9,11-18,20-27,29-36.
//   (cont.) MSB_a@2,11,20,29; cl_en_ac1@3,12,21,30; we_neg@11,20,29,38; MSB_w@11 only.
//   (cont.) we_ac2@12,21,30,39; cl_en_ac2@12; done@40.
//  Same op with accum=1 -> identical strobes except cl_en_ac2 never asserted.
//  start held high 0..41 -> ops accepted @0 and @41 only.
//   (cont.) done@40; second op we_w@42.
//  abort@15 -> @16 every strobe 0 and ready=1; no done; new start@16 gives done@56.
//  End-to-end with datapath: M=16, all act=0x7F, weight=-3 -> out_ac2 = 16*127*(-3) = -6096 at done.
//   (cont.) act=-128, weight=-8 -> out_ac2 = +16384 at done.

Source files
------------

// File: rtl/smac_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : smac_seq_if
// Purpose  : Bundle of request/status and datapath strobe signals between a
//            serial-MAC lane client and its sequencer (smac_seq_ctrl).
// Signals  : start/accum/abort   request side (client -> sequencer)
//            ready/busy/done     status (sequencer -> client)
//            act_addr/wei_addr   bit-plane addresses to act/weight buffers
//            we_w, we_br, MSB_a, we_ac1, cl_en_ac1, we_neg, MSB_w,
//            we_ac2, cl_en_ac2   datapath strobes
// Modports : master = client / datapath side, slave = sequencer
// Revision : 1.0 - initial release
// ============================================================================
interface smac_seq_if #(
  parameter int Pa = 8,
  parameter int Pw = 4
) ();
  localparam int AW = $clog2(Pa);
  localparam int WW = $clog2(Pw);

  logic          start;
  logic          accum;
  logic          abort;
  logic          ready;
  logic          busy;
  logic          done;
  logic [AW-1:0] act_addr;
  logic [WW-1:0] wei_addr;
  logic          we_w;
  logic          we_br;
  logic          MSB_a;
  logic          we_ac1;
  logic          cl_en_ac1;
  logic          we_neg;
  logic          MSB_w;
  logic          we_ac2;
  logic          cl_en_ac2;

  modport master (
    output start, accum, abort,
    input  ready, busy, done, act_addr, wei_addr,
    input  we_w, we_br, MSB_a, we_ac1, cl_en_ac1,
    input  we_neg, MSB_w, we_ac2, cl_en_ac2
  );

  modport slave (
    input  start, accum, abort,
    output ready, busy, done, act_addr, wei_addr,
    output we_w, we_br, MSB_a, we_ac1, cl_en_ac1,
    output we_neg, MSB_w, we_ac2, cl_en_ac2
  );
endinterface
`default_nettype wire

// File: rtl/smac_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : smac_seq_ctrl
// Purpose  : Sequencer for one serial-MAC lane (weight reg -> bit adder/bit
//            reg -> AC1 -> neg block -> AC2). Walks Pw weight bit-planes MSB
//            first; for each plane streams Pa activation bit-planes MSB first,
//            and pulses done once AC2 holds the final result.
// Ports    : clk  - clock, rising edge
//            rst  - asynchronous active-high reset
//            bus  - smac_seq_if.slave (request, status, addresses, strobes)
// Revision : 1.0 - initial release
// ============================================================================
module smac_seq_ctrl #(
  parameter int Pa = 8,
  parameter int Pw = 4
) (
  input  logic       clk,
  input  logic       rst,
  smac_seq_if.slave  bus
);
  localparam int AW = $clog2(Pa);
  localparam int WW = $clog2(Pw);
  localparam logic [AW-1:0] K_LAST = AW'(Pa - 1);
  localparam logic [WW-1:0] J_LAST = WW'(Pw - 1);
  localparam logic [1:0]    DRAIN_LAST = 2'd2;  // three drain cycles

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOADW  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [WW-1:0] j_q, j_d;
  logic [1:0]    drain_q, drain_d;
  logic          accum_q, accum_d;

  // Delay line: stage 1 feeds AC1, stage 2 the neg block, stage 3 AC2.
  logic ac1_we_q, ac1_we_d;
  logic ac1_cl_q, ac1_cl_d;
  logic ac1_last_q, ac1_last_d;   // this AC1 update completes a pass
  logic ac1_j0_q, ac1_j0_d;       // pass belongs to the weight sign plane
  logic neg_we_q, neg_we_d;
  logic neg_msb_q, neg_msb_d;
  logic ac2_we_q, ac2_we_d;
  logic ac2_cl_q, ac2_cl_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      j_q        <= '0;
      drain_q    <= '0;
      accum_q    <= 1'b0;
      ac1_we_q   <= 1'b0;
      ac1_cl_q   <= 1'b0;
      ac1_last_q <= 1'b0;
      ac1_j0_q   <= 1'b0;
      neg_we_q   <= 1'b0;
      neg_msb_q  <= 1'b0;
      ac2_we_q   <= 1'b0;
      ac2_cl_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      j_q        <= j_d;
      drain_q    <= drain_d;
      accum_q    <= accum_d;
      ac1_we_q   <= ac1_we_d;
      ac1_cl_q   <= ac1_cl_d;
      ac1_last_q <= ac1_last_d;
      ac1_j0_q   <= ac1_j0_d;
      neg_we_q   <= neg_we_d;
      neg_msb_q  <= neg_msb_d;
      ac2_we_q   <= ac2_we_d;
      ac2_cl_q   <= ac2_cl_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    j_d        = j_q;
    drain_d    = drain_q;
    accum_d    = accum_q;

    // Stage 1 is only loaded from STREAM; later stages always shift.
    ac1_we_d   = 1'b0;
    ac1_cl_d   = 1'b0;
    ac1_last_d = 1'b0;
    ac1_j0_d   = 1'b0;
    neg_we_d   = ac1_last_q;
    neg_msb_d  = ac1_last_q & ac1_j0_q;
    ac2_we_d   = neg_we_q;
    ac2_cl_d   = neg_we_q & neg_msb_q & ~accum_q;

    bus.ready    = 1'b0;
    bus.done     = 1'b0;
    bus.act_addr = '0;
    bus.wei_addr = '0;
    bus.we_w     = 1'b0;
    bus.we_br    = 1'b0;
    bus.MSB_a    = 1'b0;

    case (state_q)
      S_IDLE: begin
        bus.ready = 1'b1;
        if (bus.start && !bus.abort) begin
          state_d = S_LOADW;
          accum_d = bus.accum;
          k_d     = '0;
          j_d     = '0;
        end
      end
      S_LOADW: begin
        bus.we_w     = 1'b1;
        bus.wei_addr = J_LAST - j_q;
        k_d          = '0;
        state_d      = S_STREAM;
      end
      S_STREAM: begin
        bus.we_br    = 1'b1;
        bus.act_addr = K_LAST - k_q;
        bus.wei_addr = J_LAST - j_q;
        bus.MSB_a    = (k_q == '0);
        ac1_we_d     = 1'b1;
        ac1_cl_d     = (k_q == '0);
        ac1_last_d   = (k_q == K_LAST);
        ac1_j0_d     = (j_q == '0);
        if (k_q == K_LAST) begin
          k_d = '0;
          if (j_q == J_LAST) begin
            j_d     = '0;
            drain_d = '0;
            state_d = S_DRAIN;
          end else begin
            j_d     = j_q + 1'b1;
            state_d = S_LOADW;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // Lets the last pass ripple through AC1, neg and AC2.
        if (drain_q == DRAIN_LAST) begin
          drain_d = '0;
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort flushes everything so no strobe survives into the next cycle.
    if (bus.abort) begin
      state_d    = S_IDLE;
      k_d        = '0;
      j_d        = '0;
      drain_d    = '0;
      ac1_we_d   = 1'b0;
      ac1_cl_d   = 1'b0;
      ac1_last_d = 1'b0;
      ac1_j0_d   = 1'b0;
      neg_we_d   = 1'b0;
      neg_msb_d  = 1'b0;
      ac2_we_d   = 1'b0;
      ac2_cl_d   = 1'b0;
    end
  end

  assign bus.busy      = ~bus.ready;
  assign bus.we_ac1    = ac1_we_q;
  assign bus.cl_en_ac1 = ac1_cl_q;
  assign bus.we_neg    = neg_we_q;
  assign bus.MSB_w     = neg_msb_q;
  assign bus.we_ac2    = ac2_we_q;
  assign bus.cl_en_ac2 = ac2_cl_q;
endmodule
`default_nettype wire

// File: tb/tb_smac_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_smac_seq_ctrl
// Purpose  : Self-checking bench for smac_seq_ctrl. A timeline model derives
//            every output from the cycle offset since start acceptance; a
//            small behavioural datapath turns the strobes into an AC2 value.
// Revision : 1.0 - initial release
// ============================================================================
module tb_smac_seq_ctrl;
  localparam int PA = 8;
  localparam int PW = 4;
  localparam int AW = 3;
  localparam int WW = 2;
  localparam int L  = PA + 1;          // cycles per weight plane
  localparam int D  = PW * L + 4;      // done offset
  localparam int M  = 16;              // lanes summed by the bit adder
  localparam int VW = 12 + AW + WW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  smac_seq_if #(.Pa(PA), .Pw(PW)) bus ();
  smac_seq_ctrl #(.Pa(PA), .Pw(PW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // timeline model state
  bit m_act = 1'b0;
  int m_t   = 0;
  bit m_acc = 1'b0;

  // behavioural datapath
  logic [7:0] act_val;
  logic [3:0] wei_val;
  logic       wreg;
  int br, ac1, negv, ac2, exp_ac2;
  bit dp_valid;

  logic [63:0] lg_we_w, lg_we_br, lg_msba, lg_cl1, lg_neg, lg_msbw;
  logic [63:0] lg_ac2, lg_cl2, lg_done, lg_ready;

  function automatic logic [VW-1:0] model_vec(bit act, int t, bit acc);
    logic rdy, bsy, dn, ww, wbr, ma, a1, c1, ng, mw, a2, c2;
    logic [AW-1:0] aa;
    logic [WW-1:0] wa;
    int p, r, u;
    {bsy, dn, ww, wbr, ma, a1, c1, ng, mw, a2, c2} = '0;
    rdy = 1'b1;
    aa  = '0;
    wa  = '0;
    if (act) begin
      rdy = 1'b0;
      bsy = 1'b1;
      if (t >= 1 && t <= PW * L) begin
        p  = (t - 1) / L;
        r  = (t - 1) % L;
        wa = WW'(PW - 1 - p);
        ww = (r == 0);
        if (r >= 1) begin
          wbr = 1'b1;
          aa  = AW'(PA - r);
          ma  = (r == 1);
        end
      end
      if (t >= 2 && t <= PW * L + 1) begin
        r  = (t - 2) % L;
        a1 = (r >= 1);
        c1 = (r == 1);
      end
      u = t - 2;
      if (u >= L && (u % L) == 0 && (u / L) <= PW) begin
        ng = 1'b1;
        mw = ((u / L) == 1);
      end
      u = t - 3;
      if (u >= L && (u % L) == 0 && (u / L) <= PW) begin
        a2 = 1'b1;
        c2 = ((u / L) == 1) && !acc;
      end
      dn = (t == D);
    end
    return {rdy, bsy, dn, ww, wbr, ma, a1, c1, ng, mw, a2, c2, aa, wa};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {bus.ready, bus.busy, bus.done, bus.we_w, bus.we_br, bus.MSB_a,
            bus.we_ac1, bus.cl_en_ac1, bus.we_neg, bus.MSB_w, bus.we_ac2,
            bus.cl_en_ac2, bus.act_addr, bus.wei_addr};
  endfunction

  function automatic logic [63:0] rng(int lo, int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] b(int i);
    return rng(i, i);
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  task automatic tick(int rel);
    logic [VW-1:0] e, a;
    int bit_v;
    @(negedge clk);
    e = model_vec(m_act && !rst, m_t, m_acc);
    a = dut_vec();
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL outputs cycle %0d: got %b want %b", cyc, a, e);

    if (rel >= 0 && rel < 64) begin
      lg_we_w[rel]  = bus.we_w;
      lg_we_br[rel] = bus.we_br;
      lg_msba[rel]  = bus.MSB_a;
      lg_cl1[rel]   = bus.cl_en_ac1;
      lg_neg[rel]   = bus.we_neg;
      lg_msbw[rel]  = bus.MSB_w;
      lg_ac2[rel]   = bus.we_ac2;
      lg_cl2[rel]   = bus.cl_en_ac2;
      lg_done[rel]  = bus.done;
      lg_ready[rel] = bus.ready;
    end

    // datapath, updated back-to-front so each stage sees old upstream values
    if (rst) begin
      wreg = 1'b0; br = 0; ac1 = 0; negv = 0; ac2 = 0;
    end else begin
      if (bus.done && dp_valid) begin
        n_chk++;
        if (ac2 == exp_ac2) n_pass++;
        else $display("FAIL out_ac2 cycle %0d: got %0d want %0d", cyc, ac2, exp_ac2);
      end
      if (bus.we_ac2) ac2 = bus.cl_en_ac2 ? negv : 2 * ac2 + negv;
      if (bus.we_neg) negv = bus.MSB_w ? -ac1 : ac1;
      if (bus.we_ac1) ac1 = bus.cl_en_ac1 ? br : 2 * ac1 + br;
      if (bus.we_br) begin
        bit_v = (act_val[bus.act_addr] & wreg) ? M : 0;
        br = bus.MSB_a ? -bit_v : bit_v;
      end
      if (bus.we_w) wreg = wei_val[bus.wei_addr];
    end

    if (rst) m_act = 1'b0;
    else if (m_act) begin
      if (bus.abort || m_t == D) m_act = 1'b0;
      else m_t++;
    end else if (bus.start && !bus.abort) begin
      m_act = 1'b1;
      m_t   = 1;
      m_acc = bus.accum;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(int n, int s_lo, int s_hi, int s_x, bit acc, int ab_at, int rst_at);
    {lg_we_w, lg_we_br, lg_msba, lg_cl1, lg_neg} = '0;
    {lg_msbw, lg_ac2, lg_cl2, lg_done, lg_ready} = '0;
    for (int rel = 0; rel < n; rel++) begin
      bus.start = (rel >= s_lo && rel <= s_hi) || rel == s_x;
      bus.accum = acc;
      bus.abort = (rel == ab_at);
      rst       = (rel == rst_at);
      tick(rel);
    end
    bus.start = 1'b0;
    bus.accum = 1'b0;
    bus.abort = 1'b0;
    rst       = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.accum = 1'b0;
    bus.abort = 1'b0;
    act_val = 8'h7F;
    wei_val = 4'hD;
    wreg = 1'b0; br = 0; ac1 = 0; negv = 0; ac2 = 0;
    exp_ac2 = 0;
    dp_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick(-1);
    rst = 1'b0;
    tick(-1);

    // A: accum=0, act=127, weight=-3
    act_val = 8'h7F; wei_val = 4'hD; exp_ac2 = -6096; dp_valid = 1'b1;
    run(46, 0, 0, -1, 1'b0, -1, -1);
    chk("A_we_w",      lg_we_w,  b(1) | b(10) | b(19) | b(28));
    chk("A_we_br",     lg_we_br, rng(2, 9) | rng(11, 18) | rng(20, 27) | rng(29, 36));
    chk("A_MSB_a",     lg_msba,  b(2) | b(11) | b(20) | b(29));
    chk("A_cl_en_ac1", lg_cl1,   b(3) | b(12) | b(21) | b(30));
    chk("A_we_neg",    lg_neg,   b(11) | b(20) | b(29) | b(38));
    chk("A_MSB_w",     lg_msbw,  b(11));
    chk("A_we_ac2",    lg_ac2,   b(12) | b(21) | b(30) | b(39));
    chk("A_cl_en_ac2", lg_cl2,   b(12));
    chk("A_done",      lg_done,  b(40));

    // B: same op with accum=1
    dp_valid = 1'b0;
    run(46, 0, 0, -1, 1'b1, -1, -1);
    chk("B_cl_en_ac2", lg_cl2,  64'd0);
    chk("B_we_ac2",    lg_ac2,  b(12) | b(21) | b(30) | b(39));
    chk("B_done",      lg_done, b(40));

    // C: start held 0..41, act=-128, weight=-8
    act_val = 8'h80; wei_val = 4'h8; exp_ac2 = 16384; dp_valid = 1'b1;
    run(84, 0, 41, -1, 1'b0, -1, -1);
    chk("C_done",  lg_done, b(40));
    chk("C_we_w",  lg_we_w, b(1) | b(10) | b(19) | b(28) | b(42) | b(51) | b(60));

    // D: abort@15, restart@16
    run(60, 0, 0, 16, 1'b0, 15, -1);
    chk("D_done",    lg_done, b(56));
    chk("D_ready16", {63'd0, lg_ready[16]}, 64'd1);

    // E: reset in the DONE cycle, then reset mid-stream
    run(44, 0, 0, -1, 1'b0, -1, 40);
    chk("E_done_rst40", lg_done, 64'd0);
    run(30, 0, 0, -1, 1'b0, -1, 20);
    chk("E_ready_rst20", lg_ready & rng(20, 29), rng(20, 29));

    // F: abort together with start in IDLE
    run(4, 0, 0, -1, 1'b0, 0, -1);
    chk("F_ready", lg_ready & rng(0, 3), rng(0, 3));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
